// File: rtl/flasher_datapath.sv
// Datapath for the LED flasher: registered main state, saturating 5-bit counter,
// flick button synchronizer, kickback decode and a thermometer-coded LED register.
module flasher_datapath #(
  parameter int SYNC_STAGES = 2,
  parameter int LED_NUM     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flick_in,
  input  logic [2:0]         main_state_n,
  input  logic [4:0]         counter_load,
  input  logic               counter_load_en,
  input  logic [1:0]         count_state,
  output logic [2:0]         main_state,
  output logic [4:0]         counter,
  output logic               flick,
  output logic               kickback_match,
  output logic [LED_NUM-1:0] led
);

  typedef enum logic [2:0] {
    INIT       = 3'd0,
    ONLED0_15  = 3'd1,
    OFFLED15_5 = 3'd2,
    ONLED5_10  = 3'd3,
    OFFLED10_0 = 3'd4,
    ONLED0_5   = 3'd5,
    OFFLED5_0  = 3'd6
  } state_e;

  localparam logic [1:0] COUNT_UP_EN   = 2'd1;
  localparam logic [1:0] COUNT_DOWN_EN = 2'd2;

  state_e                   state_q, state_d;
  logic [4:0]               counter_q, counter_d;
  logic [LED_NUM-1:0]       led_q, led_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;

  // Encoding 7 is not a legal state; fall back to INIT.
  always_comb begin
    state_d = INIT;
    if (main_state_n != 3'd7) state_d = state_e'(main_state_n);
  end

  // Load has priority over counting; count_state=3 behaves as disabled.
  always_comb begin
    counter_d = counter_q;
    if (counter_load_en) begin
      counter_d = counter_load;
    end else if (count_state == COUNT_UP_EN) begin
      if (counter_q != 5'd31) counter_d = counter_q + 5'd1;
    end else if (count_state == COUNT_DOWN_EN) begin
      if (counter_q != 5'd0) counter_d = counter_q - 5'd1;
    end
  end

  // LEDs are built from next-cycle values so they line up with counter/state.
  always_comb begin
    led_d = '0;
    if (state_d != INIT) begin
      for (int i = 0; i < LED_NUM; i++) begin
        led_d[i] = (counter_d > 5'(i));
      end
    end
  end

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], flick_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      counter_q <= '0;
      led_q     <= '0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      led_q     <= led_d;
      sync_q    <= sync_d;
    end
  end

  assign main_state = state_q;
  assign counter    = counter_q;
  assign led        = led_q;
  assign flick      = sync_q[SYNC_STAGES-1];

  // Decoded only from registers, so flick_in never reaches an output combinationally.
  assign kickback_match = flick &&
                          (((state_q == OFFLED15_5) && (counter_q == 5'd5)) ||
                           ((state_q == OFFLED10_0) && (counter_q == 5'd0)));

endmodule

// File: tb/tb_flasher_datapath.sv
// Scoreboard bench for flasher_datapath: stimulus pushes expected post-edge
// outputs from a behavioural model, a monitor pops and compares after each edge.
module tb_flasher_datapath;

  localparam int SYNC_STAGES = 2;
  localparam int LED_NUM     = 16;
  localparam int W           = 26;

  logic               clk;
  logic               rst;
  logic               flick_in;
  logic [2:0]         main_state_n;
  logic [4:0]         counter_load;
  logic               counter_load_en;
  logic [1:0]         count_state;
  logic [2:0]         main_state;
  logic [4:0]         counter;
  logic               flick;
  logic               kickback_match;
  logic [LED_NUM-1:0] led;

  // Expected word: {state[25:23], counter[22:18], flick[17], kick[16], led[15:0]}
  logic [W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  int m_st  = 0;
  int m_cnt = 0;
  bit sync_m[$];

  flasher_datapath #(
    .SYNC_STAGES(SYNC_STAGES),
    .LED_NUM    (LED_NUM)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flick_in       (flick_in),
    .main_state_n   (main_state_n),
    .counter_load   (counter_load),
    .counter_load_en(counter_load_en),
    .count_state    (count_state),
    .main_state     (main_state),
    .counter        (counter),
    .flick          (flick),
    .kickback_match (kickback_match),
    .led            (led)
  );

  // Clock / reset-level defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: apply one cycle of inputs and push the model's post-edge outputs.
  task automatic step(input bit r, input bit fin, input int msn, input int cl,
                      input bit cle, input int cs);
    bit m_fl;
    bit m_kb;
    logic [15:0] m_led;
    @(negedge clk);
    rst             = r;
    flick_in        = fin;
    main_state_n    = 3'(msn);
    counter_load    = 5'(cl);
    counter_load_en = cle;
    count_state     = 2'(cs);
    if (r) begin
      m_st  = 0;
      m_cnt = 0;
      foreach (sync_m[i]) sync_m[i] = 1'b0;
    end else begin
      m_st = (msn == 7) ? 0 : msn;
      if (cle)          m_cnt = cl;
      else if (cs == 1) m_cnt = (m_cnt >= 31) ? 31 : m_cnt + 1;
      else if (cs == 2) m_cnt = (m_cnt <= 0) ? 0 : m_cnt - 1;
      sync_m.push_back(fin);
      void'(sync_m.pop_front());
    end
    m_fl = sync_m[0];
    m_kb = m_fl && ((m_st == 2 && m_cnt == 5) || (m_st == 4 && m_cnt == 0));
    if (m_st == 0)        m_led = 16'h0000;
    else if (m_cnt >= 16) m_led = 16'hFFFF;
    else                  m_led = 16'((32'd1 << m_cnt) - 32'd1);
    exp_q.push_back({3'(m_st), 5'(m_cnt), m_fl, m_kb, m_led});
  endtask

  // Monitor: compare each registered result just after its edge.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("main_state",     32'(main_state),     32'(e[25:23]));
        check("counter",        32'(counter),        32'(e[22:18]));
        check("flick",          32'(flick),          32'(e[17]));
        check("kickback_match", 32'(kickback_match), 32'(e[16]));
        check("led",            32'(led),            32'(e[15:0]));
      end
    end
  end

  initial begin
    rst = 1'b1; flick_in = 1'b0; main_state_n = '0; counter_load = '0;
    counter_load_en = 1'b0; count_state = '0;
    for (int i = 0; i < SYNC_STAGES; i++) sync_m.push_back(1'b0);

    // Reset with flick_in high, then release and watch flick arrive.
    step(1, 1, 3, 9, 1, 1);
    step(1, 1, 3, 9, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);

    // Up count 16 cycles from zero, then reload 3.
    for (int i = 0; i < 16; i++) step(0, 1, 1, 0, 0, 1);
    step(0, 1, 1, 3, 1, 0);

    // Kickback in OFFLED15_5 at 5, then load beats count-down.
    step(0, 1, 2, 5, 1, 0);
    step(0, 1, 2, 0, 0, 0);
    step(0, 1, 2, 16, 1, 2);
    // Kickback in OFFLED10_0 at 0.
    step(0, 1, 4, 0, 1, 0);
    step(0, 0, 4, 0, 0, 0);
    step(0, 0, 4, 0, 0, 0);

    // Saturation at both ends and count_state=3 hold.
    step(0, 0, 3, 0, 1, 0);
    step(0, 0, 3, 0, 0, 2);
    step(0, 0, 3, 0, 0, 2);
    step(0, 0, 3, 31, 1, 0);
    step(0, 0, 3, 0, 0, 1);
    step(0, 0, 3, 0, 0, 1);
    step(0, 0, 3, 0, 0, 3);

    // Illegal state, INIT blanking, OFFLED5_0 never kicks back.
    step(0, 1, 7, 10, 1, 0);
    step(0, 1, 0, 10, 1, 0);
    step(0, 1, 6, 0, 1, 0);
    step(0, 1, 6, 0, 0, 0);

    // Mid-sequence reset overrides everything.
    step(0, 1, 5, 20, 1, 0);
    step(1, 1, 5, 20, 1, 1);
    step(0, 1, 5, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7), $urandom_range(0, 31),
           ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    // Drain: the monitor must have consumed every expectation.
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
